// File: rtl/adc_frame_packer.sv
// Packs one multi-channel ADC conversion into a tagged, sequenced frame for the capture FIFO.
// Frame layout: one header word {A5, drop, NCHAN-1, seq}, then one word per channel {ch, sign-extended sample}.
module adc_frame_packer #(
    parameter int NCHAN    = 2,
    parameter int SAMPLE_W = 24
) (
    input  logic                      i_capture_clk,
    input  logic                      i_rst,
    input  logic                      i_enable,
    input  logic                      i_sample_valid,
    input  logic [NCHAN*SAMPLE_W-1:0] i_sample_data,
    input  logic                      i_capture_full,
    output logic [31:0]               o_capture_data,
    output logic                      o_capture_en,
    output logic [15:0]               o_overrun_count,
    output logic                      o_busy
);
    typedef enum logic [1:0] {S_IDLE, S_HDR, S_CH} state_t;

    localparam logic [3:0] LAST_CH = 4'(NCHAN - 1);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [3:0]                r_ch;
    logic [15:0]               r_seq;
    logic                      r_drop_flag;
    logic [NCHAN*SAMPLE_W-1:0] r_hold;
    logic [31:0]               r_capture_data;
    logic [15:0]               r_overrun_count;

    logic                      w_busy;
    logic                      w_write;
    logic                      w_accept;
    logic                      w_drop;
    logic                      w_last;
    logic                      w_hdr_write;
    logic [3:0]                w_next_ch;
    logic [SAMPLE_W-1:0]       w_sample;
    logic [31:0]               w_ch_word;
    logic [31:0]               w_hdr_word;

    always_ff @(posedge i_capture_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = S_HDR;
            S_HDR:  if (w_write) w_state_next = S_CH;
            S_CH:   if (w_write && w_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy      = (r_state != S_IDLE);
        w_write     = w_busy && !i_capture_full;
        w_accept    = (r_state == S_IDLE) && i_sample_valid && i_enable && !i_capture_full;
        w_drop      = i_sample_valid && i_enable && (w_busy || i_capture_full);
        w_last      = (r_state == S_CH) && (r_ch == LAST_CH);
        w_hdr_write = w_write && (r_state == S_HDR);
    end

    // The word loaded on a write is the one for the channel that follows the word just written.
    always_comb begin
        w_next_ch = (r_state == S_CH) ? r_ch + 4'd1 : 4'd0;
        w_sample  = '0;
        for (int k = 0; k < NCHAN; k++) begin
            if (w_next_ch == 4'(k)) w_sample = r_hold[k*SAMPLE_W +: SAMPLE_W];
        end
        w_ch_word  = {4'h0, w_next_ch, 24'(signed'(w_sample))};
        w_hdr_word = {8'hA5, 3'b000, r_drop_flag, LAST_CH, r_seq};
    end

    always_ff @(posedge i_capture_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ch            <= '0;
            r_seq           <= '0;
            r_drop_flag     <= 1'b0;
            r_hold          <= '0;
            r_capture_data  <= '0;
            r_overrun_count <= '0;
        end else begin
            if (w_accept) begin
                r_hold         <= i_sample_data;
                r_capture_data <= w_hdr_word;
            end else if (w_write && !w_last) begin
                r_capture_data <= w_ch_word;
            end

            if (w_hdr_write) begin
                r_ch <= 4'd0;
            end else if (w_write && (r_state == S_CH) && !w_last) begin
                r_ch <= r_ch + 4'd1;
            end

            if (w_write && w_last) begin
                r_seq <= r_seq + 16'd1;
            end

            // A drop in the header-write cycle must survive so the next header reports it.
            if (w_drop) begin
                r_drop_flag <= 1'b1;
                if (r_overrun_count != 16'hFFFF) r_overrun_count <= r_overrun_count + 16'd1;
            end else if (w_hdr_write) begin
                r_drop_flag <= 1'b0;
            end
        end
    end

    assign o_capture_data  = r_capture_data;
    assign o_capture_en    = w_write;
    assign o_overrun_count = r_overrun_count;
    assign o_busy          = w_busy;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Bench for adc_frame_packer: directed scenarios plus random traffic against a frame-queue model.
module tb_adc_frame_packer;
    localparam int NCH   = 2;
    localparam int SW    = 24;
    localparam int NCH_B = 3;
    localparam int SW_B  = 16;

    logic                  clk  = 1'b0;
    logic                  rst  = 1'b1;
    logic                  en   = 1'b0;
    logic                  sv   = 1'b0;
    logic                  full = 1'b0;
    logic [NCH*SW-1:0]     sd   = '0;
    logic [31:0]           cd;
    logic                  ce;
    logic [15:0]           oc;
    logic                  busy;

    logic                  sv_b = 1'b0;
    logic [NCH_B*SW_B-1:0] sd_b = '0;
    logic [31:0]           cd_b;
    logic                  ce_b;
    logic [15:0]           oc_b;
    logic                  busy_b;

    int          n_pass  = 0;
    int          n_total = 0;
    int          n_busy  = 0;
    logic [31:0] m_q[$];
    logic [15:0] m_seq  = '0;
    logic [15:0] m_oc   = '0;
    logic        m_flag = 1'b0;
    logic [31:0] a_log[$];
    logic [31:0] b_log[$];

    always #5 clk = ~clk;

    adc_frame_packer #(.NCHAN(NCH), .SAMPLE_W(SW)) dut (
        .i_capture_clk  (clk),
        .i_rst          (rst),
        .i_enable       (en),
        .i_sample_valid (sv),
        .i_sample_data  (sd),
        .i_capture_full (full),
        .o_capture_data (cd),
        .o_capture_en   (ce),
        .o_overrun_count(oc),
        .o_busy         (busy)
    );

    adc_frame_packer #(.NCHAN(NCH_B), .SAMPLE_W(SW_B)) dut_b (
        .i_capture_clk  (clk),
        .i_rst          (rst),
        .i_enable       (1'b1),
        .i_sample_valid (sv_b),
        .i_sample_data  (sd_b),
        .i_capture_full (1'b0),
        .o_capture_data (cd_b),
        .o_capture_en   (ce_b),
        .o_overrun_count(oc_b),
        .o_busy         (busy_b)
    );

    always @(negedge clk) begin
        if (ce)   a_log.push_back(cd);
        if (ce_b) b_log.push_back(cd_b);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ch_word(input int k, input logic [SW-1:0] s);
        logic signed [SW-1:0] ss;
        logic signed [23:0]   ext;
        ss  = s;
        ext = 24'(ss);
        return {4'h0, 4'(k), ext};
    endfunction

    // One clock: compare outputs with the model mid-cycle, then advance the model across the edge.
    task automatic step();
        logic m_busy;
        logic wr;
        logic drop;
        @(negedge clk);
        m_busy = (m_q.size() != 0);
        if (busy) n_busy++;
        check("busy", 32'(busy), 32'(m_busy));
        check("capture_en", 32'(ce), 32'(m_busy && !full));
        check("overrun", 32'(oc), 32'(m_oc));
        if (m_busy) check("capture_data", cd, m_q[0]);
        wr   = m_busy && !full;
        drop = sv && en && (m_busy || full);
        if (wr) begin
            if (m_q.size() == NCH + 1) m_flag = 1'b0;
            void'(m_q.pop_front());
        end
        if (drop) begin
            if (m_oc != 16'hFFFF) m_oc++;
            m_flag = 1'b1;
        end else if (sv && en && !m_busy && !full) begin
            m_q.push_back({8'hA5, 3'b000, m_flag, 4'(NCH - 1), m_seq});
            for (int k = 0; k < NCH; k++) m_q.push_back(ch_word(k, sd[k*SW +: SW]));
            m_seq++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [NCH*SW-1:0] d);
        sd = d;
        sv = 1'b1;
        step();
        sv = 1'b0;
    endtask

    initial begin
        logic [63:0] r64;
        en   = 1'b1;
        full = 1'b0;
        #12;
        check("rst_data", cd, 32'h0);
        check("rst_en", 32'(ce), 32'h0);
        check("rst_ovr", 32'(oc), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // basic frame and its latency
        a_log.delete();
        n_busy = 0;
        send({24'h000005, 24'h800001});
        repeat (5) step();
        check("basic_nwr", 32'(a_log.size()), 32'd3);
        check("basic_busy_cycles", 32'(n_busy), 32'd3);
        if (a_log.size() == 3) begin
            check("basic_hdr", a_log[0], 32'hA5010000);
            check("basic_ch0", a_log[1], 32'h00800001);
            check("basic_ch1", a_log[2], 32'h01000005);
        end

        // 16-bit samples sign-extend into the 24-bit field
        b_log.delete();
        sd_b = {16'h0001, 16'h7FFF, 16'h8000};
        sv_b = 1'b1;
        step();
        sv_b = 1'b0;
        repeat (6) step();
        check("b_nwr", 32'(b_log.size()), 32'd4);
        if (b_log.size() == 4) begin
            check("b_hdr", b_log[0], 32'hA5020000);
            check("b_ch0_sext", b_log[1], 32'h00FF8000);
            check("b_ch1", b_log[2], 32'h01007FFF);
            check("b_ch2", b_log[3], 32'h02000001);
        end
        check("b_busy_idle", 32'(busy_b), 32'h0);
        check("b_ovr", 32'(oc_b), 32'h0);

        // FIFO full for five cycles after the header
        a_log.delete();
        send({24'h123456, 24'hFEDCBA});
        step();
        full = 1'b1;
        repeat (5) begin
            step();
            check("stall_data", cd, 32'h00FEDCBA);
        end
        full = 1'b0;
        repeat (4) step();
        check("stall_nwr", 32'(a_log.size()), 32'd3);
        if (a_log.size() == 3) begin
            check("stall_hdr", a_log[0], 32'hA5010001);
            check("stall_ch0", a_log[1], 32'h00FEDCBA);
            check("stall_ch1", a_log[2], 32'h01123456);
        end

        // conversion dropped in IDLE because the FIFO is full
        full = 1'b1;
        send({24'h111111, 24'h222222});
        full = 1'b0;
        check("idle_drop_ovr", 32'(oc), 32'd1);
        a_log.delete();
        send({24'h000001, 24'h000002});
        repeat (4) step();
        send({24'h000003, 24'h000004});
        repeat (4) step();
        check("idle_drop_nwr", 32'(a_log.size()), 32'd6);
        if (a_log.size() == 6) begin
            check("drop_hdr_flag", 32'(a_log[0][20]), 32'd1);
            check("drop_hdr_seq", 32'(a_log[0][15:0]), 32'd2);
            check("next_hdr_flag", 32'(a_log[3][20]), 32'd0);
            check("next_hdr_seq", 32'(a_log[3][15:0]), 32'd3);
        end

        // conversion arriving during the final channel word
        send({24'h0000AA, 24'h0000BB});
        step();
        step();
        sv = 1'b1;
        step();
        sv = 1'b0;
        check("last_cycle_drop_ovr", 32'(oc), 32'd2);
        a_log.delete();
        send({24'h0000CC, 24'h0000DD});
        repeat (4) step();
        if (a_log.size() != 0) check("last_drop_hdr_flag", 32'(a_log[0][20]), 32'd1);
        else check("last_drop_nwr", 32'(a_log.size()), 32'd3);

        // sequence wrap
        force dut.r_seq = 16'hFFFF;
        m_seq = 16'hFFFF;
        step();
        release dut.r_seq;
        a_log.delete();
        send({24'h000010, 24'h000020});
        repeat (4) step();
        send({24'h000030, 24'h000040});
        repeat (4) step();
        check("wrap_nwr", 32'(a_log.size()), 32'd6);
        if (a_log.size() == 6) begin
            check("wrap_seq_ffff", 32'(a_log[0][15:0]), 32'h0000FFFF);
            check("wrap_seq_0", 32'(a_log[3][15:0]), 32'h0);
        end

        // overrun counter saturates
        force dut.r_overrun_count = 16'hFFFF;
        m_oc = 16'hFFFF;
        step();
        release dut.r_overrun_count;
        full = 1'b1;
        send({24'h0, 24'h0});
        full = 1'b0;
        check("ovr_saturate", 32'(oc), 32'h0000FFFF);

        // reset in the middle of a frame (CH, ch=1)
        send({24'h0BEEF0, 24'h0CAFE0});
        step();
        step();
        #2 rst = 1'b1;
        #1;
        check("midrst_data", cd, 32'h0);
        check("midrst_en", 32'(ce), 32'h0);
        check("midrst_ovr", 32'(oc), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        m_q.delete();
        m_seq  = '0;
        m_oc   = '0;
        m_flag = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        a_log.delete();
        send({24'h000777, 24'h000888});
        repeat (4) step();
        check("postrst_nwr", 32'(a_log.size()), 32'd3);
        if (a_log.size() != 0) check("postrst_hdr", a_log[0], 32'hA5010000);

        // random traffic against the model
        repeat (3000) begin
            en   = ($urandom_range(7) != 0);
            sv   = ($urandom_range(2) == 0);
            full = ($urandom_range(3) == 0);
            r64  = {$urandom(), $urandom()};
            sd   = r64[NCH*SW-1:0];
            step();
        end
        en   = 1'b1;
        sv   = 1'b0;
        full = 1'b0;
        repeat (6) step();
        check("drain_busy", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
